// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals shared between the CPU ports, the arbiter and the RAM.
// slave is the arbiter's view; master is the CPU-plus-RAM environment's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the instruction-fetch and load/store ports.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive conflict losses.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic              cpu_stall,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_LD   = 2'd2,
    RESP_ST   = 2'd3
  } resp_e;

  resp_e               resp_q;
  resp_e               resp_d;
  logic [STARVE_W-1:0] starve_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                conflict;
  logic                starve_full;
  logic                if_gnt_c;
  logic                d_gnt_c;

  assign conflict    = bus.if_req & bus.d_req;
  assign starve_full = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign if_gnt_c    = ~rst & bus.if_req & (~bus.d_req | starve_full);
  assign d_gnt_c     = ~rst & bus.d_req & ~if_gnt_c;

  // Response-source register: remembers who owns the RAM read data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= RESP_NONE;
    end else begin
      resp_q <= resp_d;
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    if (if_gnt_c) begin
      resp_d = RESP_IF;
    end else if (d_gnt_c) begin
      resp_d = bus.d_we ? RESP_ST : RESP_LD;
    end
  end

  // Grants and RAM drive follow the winner; responses forward RAM data in the valid cycle.
  always_comb begin
    bus.if_gnt    = if_gnt_c;
    bus.d_gnt     = d_gnt_c;
    bus.ram_we    = d_gnt_c & bus.d_we;
    bus.ram_addr  = ADDR_W'(0);
    bus.ram_wdata = DATA_W'(0);
    bus.if_valid  = 1'b0;
    bus.d_valid   = 1'b0;
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;
    cpu_stall     = ~rst & ((bus.if_req & ~if_gnt_c) | (bus.d_req & ~d_gnt_c));
    if (if_gnt_c) begin
      bus.ram_addr = bus.if_addr;
    end else if (d_gnt_c) begin
      bus.ram_addr  = bus.d_addr;
      bus.ram_wdata = bus.d_wdata;
    end
    if (rst) begin
      bus.if_rdata = DATA_W'(0);
      bus.d_rdata  = DATA_W'(0);
    end else begin
      case (resp_q)
        RESP_IF: begin
          bus.if_valid = 1'b1;
          bus.if_rdata = bus.ram_rdata;
        end
        RESP_LD: begin
          bus.d_valid = 1'b1;
          bus.d_rdata = bus.ram_rdata;
        end
        RESP_ST: bus.d_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Starvation and conflict counters plus the held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= '0;
      conflict_cnt <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (conflict && d_gnt_c) begin
        starve_q <= starve_q + STARVE_W'(1);
      end else begin
        starve_q <= '0;
      end
      if (conflict && (conflict_cnt != 16'hFFFF)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (resp_q == RESP_IF) begin
        if_rdata_q <= bus.ram_rdata;
      end
      if (resp_q == RESP_LD) begin
        d_rdata_q <= bus.ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural model with its own copy of memory.
module tb_mem_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int          LIMIT = 3;

  logic        clk;
  logic        rst;
  logic        cpu_stall;
  logic [15:0] conflict_cnt;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .cpu_stall    (cpu_stall),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, one-cycle read latency.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_tests;
  int n_fail;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd);
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
  endtask

  typedef struct {
    logic        ifr;
    logic [15:0] ifa;
    logic        dr;
    logic        dwe;
    logic [15:0] da;
    logic [15:0] dwd;
    logic        e_ifg;
    logic        e_dg;
    logic        e_stall;
    logic        e_we;
    logic [15:0] e_raddr;
    logic        e_ifv;
    logic [15:0] e_ifd;
    logic        e_dv;
    logic [15:0] e_dd;
    logic [15:0] e_conf;
  } vec_t;

  vec_t tbl [14];

  // Model state for the randomized phase.
  logic [15:0] m_mem [16];
  int          m_dwins;
  int          m_conf;
  logic        m_ifv;
  logic        m_dv;
  logic [15:0] m_if_rdata;
  logic [15:0] m_d_rdata;

  logic        r_ifr, r_dr, r_dwe;
  logic [15:0] r_ifa, r_da, r_dwd;
  logic        g_if, g_d;
  logic        e_ifg, e_dg, e_we, e_stall;
  logic [15:0] e_raddr;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h00A0;
    mem[1] = 16'h00A1;
    mem[2] = 16'h00A2;
    mem[3] = 16'h00A3;

    //          ifr ifa   dr we da    wd     ifg dg st we raddr  ifv ifd      dv dd       conf
    tbl[0]  = '{1, 16'd0, 0, 0, 16'd0, 16'd0, 1, 0, 0, 0, 16'd0, 0, 16'h0000, 0, 16'h0000, 16'd0};
    tbl[1]  = '{1, 16'd1, 0, 0, 16'd0, 16'd0, 1, 0, 0, 0, 16'd1, 1, 16'h00A0, 0, 16'h0000, 16'd0};
    tbl[2]  = '{1, 16'd2, 0, 0, 16'd0, 16'd0, 1, 0, 0, 0, 16'd2, 1, 16'h00A1, 0, 16'h0000, 16'd0};
    tbl[3]  = '{1, 16'd3, 0, 0, 16'd0, 16'd0, 1, 0, 0, 0, 16'd3, 1, 16'h00A2, 0, 16'h0000, 16'd0};
    tbl[4]  = '{0, 16'd0, 0, 0, 16'd0, 16'd0, 0, 0, 0, 0, 16'd0, 1, 16'h00A3, 0, 16'h0000, 16'd0};
    tbl[5]  = '{0, 16'd0, 1, 1, 16'd2, 16'd8, 0, 1, 0, 1, 16'd2, 0, 16'h00A3, 0, 16'h0000, 16'd0};
    tbl[6]  = '{0, 16'd0, 1, 0, 16'd2, 16'd0, 0, 1, 0, 0, 16'd2, 0, 16'h00A3, 1, 16'h0000, 16'd0};
    tbl[7]  = '{0, 16'd0, 0, 0, 16'd0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 16'h00A3, 1, 16'h0008, 16'd0};
    tbl[8]  = '{1, 16'd0, 1, 0, 16'd3, 16'd0, 0, 1, 1, 0, 16'd3, 0, 16'h00A3, 0, 16'h0008, 16'd0};
    tbl[9]  = '{1, 16'd0, 1, 0, 16'd3, 16'd0, 0, 1, 1, 0, 16'd3, 0, 16'h00A3, 1, 16'h00A3, 16'd1};
    tbl[10] = '{1, 16'd0, 1, 0, 16'd3, 16'd0, 0, 1, 1, 0, 16'd3, 0, 16'h00A3, 1, 16'h00A3, 16'd2};
    tbl[11] = '{1, 16'd0, 1, 0, 16'd3, 16'd0, 1, 0, 1, 0, 16'd0, 0, 16'h00A3, 1, 16'h00A3, 16'd3};
    tbl[12] = '{1, 16'd0, 1, 0, 16'd3, 16'd0, 0, 1, 1, 0, 16'd3, 1, 16'h00A0, 0, 16'h00A3, 16'd4};
    tbl[13] = '{0, 16'd0, 0, 0, 16'd0, 16'd0, 0, 0, 0, 0, 16'd0, 0, 16'h00A0, 1, 16'h00A3, 16'd5};

    // Reset with both requests high: no grant, no stall, no write.
    rst = 1'b1;
    drive(1'b1, 16'd5, 1'b1, 1'b1, 16'd6, 16'h1234);
    tick();
    tick();
    @(negedge clk);
    chk1("reset if_gnt", bus.if_gnt, 1'b0);
    chk1("reset d_gnt", bus.d_gnt, 1'b0);
    chk1("reset cpu_stall", cpu_stall, 1'b0);
    chk1("reset ram_we", bus.ram_we, 1'b0);
    chk1("reset if_valid", bus.if_valid, 1'b0);
    chk1("reset d_valid", bus.d_valid, 1'b0);
    chk16("reset conflict_cnt", conflict_cnt, 16'd0);

    // Directed table: fetch stream, store then load, conflict starvation.
    for (int i = 0; i < 14; i++) begin
      tick();
      rst = 1'b0;
      drive(tbl[i].ifr, tbl[i].ifa, tbl[i].dr, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
      @(negedge clk);
      chk1($sformatf("row%0d if_gnt", i), bus.if_gnt, tbl[i].e_ifg);
      chk1($sformatf("row%0d d_gnt", i), bus.d_gnt, tbl[i].e_dg);
      chk1($sformatf("row%0d cpu_stall", i), cpu_stall, tbl[i].e_stall);
      chk1($sformatf("row%0d ram_we", i), bus.ram_we, tbl[i].e_we);
      chk16($sformatf("row%0d ram_addr", i), bus.ram_addr, tbl[i].e_raddr);
      chk1($sformatf("row%0d if_valid", i), bus.if_valid, tbl[i].e_ifv);
      chk16($sformatf("row%0d if_rdata", i), bus.if_rdata, tbl[i].e_ifd);
      chk1($sformatf("row%0d d_valid", i), bus.d_valid, tbl[i].e_dv);
      chk16($sformatf("row%0d d_rdata", i), bus.d_rdata, tbl[i].e_dd);
      chk16($sformatf("row%0d conflict_cnt", i), conflict_cnt, tbl[i].e_conf);
    end

    // Simultaneous single requests: data first, fetch next, responses in grant order.
    tick();
    drive(1'b0, 16'd0, 1'b1, 1'b1, 16'd1, 16'd3);
    @(negedge clk);
    chk1("sim store d_gnt", bus.d_gnt, 1'b1);
    tick();
    drive(1'b1, 16'd4, 1'b1, 1'b0, 16'd1, 16'd0);
    @(negedge clk);
    chk1("sim d_gnt", bus.d_gnt, 1'b1);
    chk1("sim if_gnt held off", bus.if_gnt, 1'b0);
    chk1("sim stall", cpu_stall, 1'b1);
    tick();
    drive(1'b1, 16'd4, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    chk1("sim if_gnt", bus.if_gnt, 1'b1);
    chk1("sim d_valid", bus.d_valid, 1'b1);
    chk16("sim d_rdata", bus.d_rdata, 16'd3);
    chk1("sim if_valid early", bus.if_valid, 1'b0);
    tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    chk1("sim if_valid", bus.if_valid, 1'b1);
    chk16("sim if_rdata", bus.if_rdata, 16'h1004);
    chk1("sim d_valid gone", bus.d_valid, 1'b0);
    chk16("sim conflict_cnt", conflict_cnt, 16'd6);

    // Reset right after a fetch grant drops the pending response.
    tick();
    drive(1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    chk1("rstmid if_gnt", bus.if_gnt, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b1, 16'd1, 1'b1, 1'b0, 16'd2, 16'd0);
    @(negedge clk);
    chk1("rstmid if_valid", bus.if_valid, 1'b0);
    chk1("rstmid if_gnt", bus.if_gnt, 1'b0);
    chk1("rstmid d_gnt", bus.d_gnt, 1'b0);
    chk1("rstmid stall", cpu_stall, 1'b0);
    chk1("rstmid ram_we", bus.ram_we, 1'b0);
    chk16("rstmid if_rdata", bus.if_rdata, 16'd0);
    chk16("rstmid d_rdata", bus.d_rdata, 16'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    chk1("rstpost if_valid", bus.if_valid, 1'b0);
    chk1("rstpost d_valid", bus.d_valid, 1'b0);
    chk16("rstpost if_rdata", bus.if_rdata, 16'd0);
    chk16("rstpost d_rdata", bus.d_rdata, 16'd0);
    chk16("rstpost conflict_cnt", conflict_cnt, 16'd0);

    // Starvation history must not survive reset: two data wins, reset, then D,D,D,IF.
    for (int i = 0; i < 2; i++) begin
      tick();
      drive(1'b1, 16'd0, 1'b1, 1'b0, 16'd3, 16'd0);
      @(negedge clk);
      chk1($sformatf("prestarve%0d d_gnt", i), bus.d_gnt, 1'b1);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk1("starve rst d_valid", bus.d_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk1($sformatf("starve%0d if_gnt", i), bus.if_gnt, (i == 3));
      chk1($sformatf("starve%0d d_gnt", i), bus.d_gnt, (i != 3));
    end
    tick();
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    chk16("starve conflict_cnt", conflict_cnt, 16'd4);
    chk1("starve final d_valid", bus.d_valid, 1'b0);
    chk1("starve final if_valid", bus.if_valid, 1'b1);

    // Saturation of the conflict counter.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 16'd0, 1'b1, 1'b0, 16'd3, 16'd0);
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk16("sat near max", conflict_cnt, 16'hFFFE);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk16("sat held", conflict_cnt, 16'hFFFF);

    // Randomized traffic against the behavioural model.
    tick();
    rst = 1'b1;
    drive(1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    tick();
    for (int i = 0; i < 16; i++) m_mem[i] = mem[i];
    m_dwins    = 0;
    m_conf     = 0;
    m_ifv      = 1'b0;
    m_dv       = 1'b0;
    m_if_rdata = 16'd0;
    m_d_rdata  = 16'd0;
    r_ifr = 1'b0; r_dr = 1'b0; r_dwe = 1'b0;
    r_ifa = 16'd0; r_da = 16'd0; r_dwd = 16'd0;
    g_if = 1'b1;
    g_d  = 1'b1;
    rst  = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c != 0) tick();
      if (!r_ifr || g_if) begin
        r_ifr = ($urandom_range(0, 3) != 0);
        r_ifa = 16'($urandom_range(0, 15));
      end
      if (!r_dr || g_d) begin
        r_dr  = ($urandom_range(0, 2) != 0);
        r_dwe = 1'($urandom_range(0, 1));
        r_da  = 16'($urandom_range(0, 15));
        r_dwd = 16'($urandom);
      end
      drive(r_ifr, r_ifa, r_dr, r_dwe, r_da, r_dwd);
      @(negedge clk);
      e_ifg   = r_ifr && (!r_dr || m_dwins == LIMIT);
      e_dg    = r_dr && !e_ifg;
      e_we    = e_dg && r_dwe;
      e_stall = (r_ifr && !e_ifg) || (r_dr && !e_dg);
      e_raddr = e_ifg ? r_ifa : (e_dg ? r_da : 16'd0);
      chk1($sformatf("rnd%0d if_gnt", c), bus.if_gnt, e_ifg);
      chk1($sformatf("rnd%0d d_gnt", c), bus.d_gnt, e_dg);
      chk1($sformatf("rnd%0d cpu_stall", c), cpu_stall, e_stall);
      chk1($sformatf("rnd%0d ram_we", c), bus.ram_we, e_we);
      chk16($sformatf("rnd%0d ram_addr", c), bus.ram_addr, e_raddr);
      if (e_we) chk16($sformatf("rnd%0d ram_wdata", c), bus.ram_wdata, r_dwd);
      chk1($sformatf("rnd%0d if_valid", c), bus.if_valid, m_ifv);
      chk16($sformatf("rnd%0d if_rdata", c), bus.if_rdata, m_if_rdata);
      chk1($sformatf("rnd%0d d_valid", c), bus.d_valid, m_dv);
      chk16($sformatf("rnd%0d d_rdata", c), bus.d_rdata, m_d_rdata);
      chk16($sformatf("rnd%0d conflict_cnt", c), conflict_cnt, 16'(m_conf));
      // Advance the model by one clock.
      g_if  = bus.if_gnt;
      g_d   = bus.d_gnt;
      m_ifv = e_ifg;
      m_dv  = e_dg;
      if (e_ifg) m_if_rdata = m_mem[r_ifa[3:0]];
      if (e_dg) begin
        if (r_dwe) m_mem[r_da[3:0]] = r_dwd;
        else       m_d_rdata = m_mem[r_da[3:0]];
      end
      m_dwins = (r_ifr && r_dr && e_dg) ? m_dwins + 1 : 0;
      if (r_ifr && r_dr && m_conf < 65535) m_conf++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
